multi_button_control: RTL
=========================

MULTI_BUTTON_CONTROL -- requirements
Module: multi_button_control

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, number of candidate buttons (legal range >= 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500, count of consecutive mismatching synchronised samples before the debounced level changes (>= 1).
REQ-003 The block SHALL have parameter LONG_PRESS_CYCLES, default 11, count of debounced-high cycles that qualify a press (>= 1).
REQ-004 The block SHALL have parameter LOCKOUT_CYCLES, default 16, length of the dead time after an accepted vote (>= 1).
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port enable, input, 1 bit, election-open gate; low means qualifications are discarded.
REQ-008 The block SHALL have port button_raw, input, NUM_CHANNELS bits, asynchronous raw button levels, bit i = candidate i.
REQ-009 The block SHALL have port vote_valid, output, 1 bit, one-cycle pulse per accepted vote.
REQ-010 The block SHALL have port vote_id, output, max(1,$clog2(NUM_CHANNELS)) bits, index of the accepted channel, valid while vote_valid is high, otherwise holding its last value.
REQ-011 The block SHALL have port pressed_level, output, NUM_CHANNELS bits, registered debounced level per channel.
REQ-012 The block SHALL have port conflict, output, 1 bit, one-cycle pulse when a qualification is rejected for a multiple press.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the arbiter FSM is not in IDLE.

Function
REQ-014 Each channel SHALL pass button_raw[i] through a two-flop synchroniser.
REQ-015 Each channel SHALL increment a debounce counter while synchronised level != debounced level, SHALL update the debounced level and clear the counter on the cycle the counter equals DEBOUNCE_CYCLES, and SHALL clear the counter on any matching sample.
REQ-016 pressed_level[i] SHALL equal the debounced level delayed by one register.
REQ-017 Each channel SHALL keep a hold counter that increments while debounced high, saturates at LONG_PRESS_CYCLES, and clears when debounced low.
REQ-018 A channel SHALL raise a qualification event on exactly the cycle its hold counter equals LONG_PRESS_CYCLES-1 while debounced high; one event per press.
REQ-019 End-to-end latency SHALL be DEBOUNCE_CYCLES+LONG_PRESS_CYCLES+3 rising edges from the first edge sampling button_raw[i] high to vote_valid high.
REQ-020 The arbiter FSM SHALL have states IDLE, LOCKOUT, WAIT_RELEASE.
REQ-021 In IDLE with enable high, if exactly one channel qualifies and no other channel is debounced high, the block SHALL pulse vote_valid with vote_id = that channel on the next edge and go to LOCKOUT.
REQ-022 In IDLE with enable high, if a channel qualifies while any other channel is debounced high (including simultaneous qualifications), the block SHALL pulse conflict, SHALL NOT pulse vote_valid, and SHALL go to WAIT_RELEASE.
REQ-023 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then go to WAIT_RELEASE.
REQ-024 WAIT_RELEASE SHALL return to IDLE on the first cycle all debounced levels are low.
REQ-025 Qualification events occurring outside IDLE, or while enable is low, SHALL be discarded without any output pulse; a new vote then requires release and a new full press, since the hold counter does not re-qualify while held.
REQ-026 vote_valid and conflict SHALL never be high in the same cycle; neither SHALL be high for more than one consecutive cycle.

Reset
REQ-027 While reset is low, all synchronisers, debounced levels, counters, and outputs SHALL be 0 and the FSM SHALL be IDLE, immediately and independent of clock.
REQ-028 Reset asserted mid-press or mid-lockout SHALL abort that operation; after release, a still-held button SHALL require a full debounce and long-press before voting.

Structure
REQ-029 A shared package voting_pkg SHALL hold the arbiter state enumeration and the vote_id width helper.
REQ-030 Per-channel synchroniser, debounce, and hold logic SHALL be one sub-module, button_channel, instantiated NUM_CHANNELS times in a generate loop; arbitration and FSM SHALL stay in the top.

Verification (NUM_CHANNELS=4, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=3, LOCKOUT_CYCLES=8)
REQ-031 Hold button 2 high for 30 cycles -> vote_valid high exactly once, 10 edges after the first high sample, vote_id=2, busy high for 8 cycles of LOCKOUT and then until release.
REQ-032 Button 1 with 2-cycle glitches every 3 cycles for 40 cycles -> pressed_level[1] stays 0, no vote_valid.
REQ-033 Buttons 0 and 3 pressed on the same cycle -> one conflict pulse, no vote_valid; after both are released, a clean press of button 0 -> vote_id=0.
REQ-034 Button 1 accepted, button 2 pressed and held during LOCKOUT until after button 1 is released -> no second vote until button 2 is released and pressed again.
REQ-035 enable low during a full press of button 3 -> no output pulse; enable raised while still held -> still no vote.
REQ-036 reset pulsed low asynchronously between clock edges during a held press -> all outputs 0 at once; holding through deassertion yields a vote 10 edges later.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and helpers for the multi-button voting controller.
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } arb_state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int vote_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button input: two-flop synchroniser, debounce filter and long-press hold counter.
module button_channel #(
    parameter int DEBOUNCE_CYCLES   = 500,
    parameter int LONG_PRESS_CYCLES = 11
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic debounced,
    output logic pressed_level,
    output logic qualify
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DBW-1:0] DB_TC     = DBW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0]  HOLD_QUAL = HW'(LONG_PRESS_CYCLES - 1);

    logic           sync_meta;
    logic           sync_q;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta     <= 1'b0;
            sync_q        <= 1'b0;
            db_cnt        <= '0;
            debounced     <= 1'b0;
            hold_cnt      <= '0;
            pressed_level <= 1'b0;
        end else begin
            sync_meta     <= button_raw;
            sync_q        <= sync_meta;
            pressed_level <= debounced;

            if (sync_q == debounced) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_TC) begin
                debounced <= sync_q;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end

            // Saturating hold count so a held button qualifies only once.
            if (!debounced) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign qualify = debounced && (hold_cnt == HOLD_QUAL);

endmodule

// File: rtl/multi_button_control.sv
// Voting controller: per-button qualification plus single-vote arbitration with lockout.
//
// state        | meaning
// IDLE         | election open, waiting for a qualified press
// LOCKOUT      | dead time after an accepted vote
// WAIT_RELEASE | waiting until every debounced button is released
module multi_button_control
    import voting_pkg::*;
#(
    parameter int NUM_CHANNELS      = 4,
    parameter int DEBOUNCE_CYCLES   = 500,
    parameter int LONG_PRESS_CYCLES = 11,
    parameter int LOCKOUT_CYCLES    = 16
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic [NUM_CHANNELS-1:0]                  button_raw,
    output logic                                     vote_valid,
    output logic [vote_id_width(NUM_CHANNELS)-1:0]   vote_id,
    output logic [NUM_CHANNELS-1:0]                  pressed_level,
    output logic                                     conflict,
    output logic                                     busy
);

    localparam int IDW = vote_id_width(NUM_CHANNELS);
    localparam int LW  = vote_id_width(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic [NUM_CHANNELS-1:0] debounced;
    logic [NUM_CHANNELS-1:0] qualify;
    logic                    sole_qual;
    logic [IDW-1:0]          qual_id;
    arb_state_t              state;
    logic [LW-1:0]           lock_cnt;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .button_raw   (button_raw[ch]),
            .debounced    (debounced[ch]),
            .pressed_level(pressed_level[ch]),
            .qualify      (qualify[ch])
        );
    end

    // A vote is clean only if the qualifying button is the sole one held down.
    always_comb begin
        qual_id = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (qualify[i]) begin
                qual_id = IDW'(i);
            end
        end
        sole_qual = $onehot(qualify) && ((debounced & ~qualify) == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            vote_valid <= 1'b0;
            vote_id    <= '0;
            conflict   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vote_valid <= 1'b0;
            conflict   <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (qualify != '0)) begin
                        busy <= 1'b1;
                        if (sole_qual) begin
                            vote_valid <= 1'b1;
                            vote_id    <= qual_id;
                            lock_cnt   <= LOCK_LOAD;
                            state      <= LOCKOUT;
                        end else begin
                            conflict <= 1'b1;
                            state    <= WAIT_RELEASE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        state <= WAIT_RELEASE;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (debounced == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
